// File: rtl/dzuart_pkg.sv
// Shared DZ11 UART definitions: line-parameter encodings, baud-rate selects,
// receiver state encoding and small helpers for the character path.
package dzuart_pkg;

  typedef enum logic [1:0] {
    LEN_5 = 2'b00,
    LEN_6 = 2'b01,
    LEN_7 = 2'b10,
    LEN_8 = 2'b11
  } char_len_e;

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  typedef enum logic [3:0] {
    BAUD_50    = 4'd0,
    BAUD_75    = 4'd1,
    BAUD_110   = 4'd2,
    BAUD_134_5 = 4'd3,
    BAUD_150   = 4'd4,
    BAUD_300   = 4'd5,
    BAUD_600   = 4'd6,
    BAUD_1200  = 4'd7,
    BAUD_1800  = 4'd8,
    BAUD_2000  = 4'd9,
    BAUD_2400  = 4'd10,
    BAUD_3600  = 4'd11,
    BAUD_4800  = 4'd12,
    BAUD_7200  = 4'd13,
    BAUD_9600  = 4'd14,
    BAUD_19200 = 4'd15
  } baud_sel_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  // Index of the final data bit (0-based) for a given length code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] length);
    return 3'd4 + {1'b0, length};
  endfunction

  // Bits enter the shift register at the MSB, so a short character sits in
  // the top bits and must be moved down with zero fill.
  function automatic logic [7:0] right_justify(input logic [7:0] sr,
                                               input logic [1:0] length);
    case (char_len_e'(length))
      LEN_5:   return {3'b000, sr[7:3]};
      LEN_6:   return {2'b00, sr[7:2]};
      LEN_7:   return {1'b0, sr[7:1]};
      default: return sr;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input; resets to the
// idle (marking) level so reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// DZ11 per-line serial receiver, 16x oversampled.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting at cnt 6/7/8.
module uart_rx
  import dzuart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic [1:0] length,
  input  logic       parEN,
  input  logic       parEVEN,
  input  logic       rxd,
  input  logic       clr,
  output logic [7:0] data,
  output logic       full,
  output logic       pare,
  output logic       frme,
  output logic       ovre
);

  logic rxs;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  rx_state_e  state_q, state_d;
  logic [3:0] cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       par_bit_q;

  logic       sample, wrap, bit_val;
  logic       load, shift_en, par_cap, bit_inc;
  logic [7:0] character;
  logic       pare_next;

`ifdef UART_RX_MAJORITY_EN
  logic vote6_q, vote7_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote6_q <= 1'b1;
      vote7_q <= 1'b1;
    end else if (clken) begin
      if (cnt_q == 4'd6) vote6_q <= rxs;
      if (cnt_q == 4'd7) vote7_q <= rxs;
    end
  end

  assign sample  = clken && (cnt_q == 4'd8);
  assign bit_val = (vote6_q & vote7_q) | (vote6_q & rxs) | (vote7_q & rxs);
`else
  assign sample  = clken && (cnt_q == 4'd7);
  assign bit_val = rxs;
`endif

  assign wrap      = clken && (cnt_q == 4'd15);
  assign character = right_justify(shift_q, length);
  // Error when the total count of ones disagrees with the selected sense.
  assign pare_next = parEN & ((^character) ^ par_bit_q ^ ~parEVEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    par_cap  = 1'b0;
    bit_inc  = 1'b0;
    case (state_q)
      RX_IDLE: if (!rxs) state_d = RX_START;
      RX_START: begin
        if (sample && bit_val) state_d = RX_IDLE;
        else if (wrap)         state_d = RX_DATA;
      end
      RX_DATA: begin
        shift_en = sample;
        if (wrap) begin
          if (bit_idx_q == last_bit_idx(length))
            state_d = parEN ? RX_PARITY : RX_STOP;
          else
            bit_inc = 1'b1;
        end
      end
      RX_PARITY: begin
        par_cap = sample;
        if (wrap) state_d = RX_STOP;
      end
      RX_STOP: begin
        // Leave mid-stop-bit so the next start edge is never missed.
        if (sample) begin
          load    = 1'b1;
          state_d = bit_val ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: if (rxs) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      par_bit_q <= 1'b0;
    end else begin
      if (state_q == RX_IDLE || state_q == RX_BREAK) cnt_q <= 4'd0;
      else if (clken)                                cnt_q <= cnt_q + 4'd1;

      if (state_q != RX_DATA) bit_idx_q <= 3'd0;
      else if (bit_inc)       bit_idx_q <= bit_idx_q + 3'd1;

      if (shift_en) shift_q   <= {bit_val, shift_q[7:1]};
      if (par_cap)  par_bit_q <= bit_val;
    end
  end

  // NOTE: the result registers are reset because an aborted frame must
  // present a clean, empty receiver to the silo logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= 8'h00;
      full <= 1'b0;
      pare <= 1'b0;
      frme <= 1'b0;
      ovre <= 1'b0;
    end else if (load) begin
      // A load coinciding with clr wins: the new character stays pending.
      data <= character;
      pare <= pare_next;
      frme <= ~bit_val;
      ovre <= full & ~clr;
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed, scoreboard-driven bench for uart_rx: frame formats, parity,
// short characters, glitch rejection, overrun, clr collision, break, reset.
module tb_uart_rx;

  logic       clk, rst, clken, parEN, parEVEN, rxd, clr;
  logic [1:0] length;
  logic [7:0] data;
  logic       full, pare, frme, ovre;

  uart_rx dut (
    .clk     (clk),
    .rst     (rst),
    .clken   (clken),
    .length  (length),
    .parEN   (parEN),
    .parEVEN (parEVEN),
    .rxd     (rxd),
    .clr     (clr),
    .data    (data),
    .full    (full),
    .pare    (pare),
    .frme    (frme),
    .ovre    (ovre)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       pare;
    logic       frme;
    logic       ovre;
  } exp_t;

  exp_t sb[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   model_full = 0;
  bit   rose;
  int   rise_at;
  logic rise_clken;
  logic last_clken;
  logic [1:0] div = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x enable: one clk wide every 4 clks, so one bit time is 64 clks.
  initial begin
    clken = 1'b0;
    forever begin
      @(negedge clk);
      div   = div + 2'd1;
      clken = (div == 2'd3);
    end
  end

  always @(posedge clk) last_clken <= clken;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one frame; records the clk (within the stop bit) where full rose
  // and pulses clr during stop-bit clk clr_off (negative: never).
  task automatic send_frame(input logic [7:0] ch, input int nbits, input bit pen,
                            input bit pbit, input bit stop_val, input int clr_off);
    bit prev_full;
    rxd = 1'b0;
    repeat (64) tick();
    for (int b = 0; b < nbits; b++) begin
      rxd = ch[b];
      repeat (64) tick();
    end
    if (pen) begin
      rxd = pbit;
      repeat (64) tick();
    end
    rxd        = stop_val;
    rose       = 0;
    rise_at    = -1;
    rise_clken = 1'b0;
    prev_full  = full;
    for (int i = 0; i < 64; i++) begin
      clr = (i == clr_off);
      tick();
      clr = 1'b0;
      if (!rose && !prev_full && full) begin
        rose       = 1;
        rise_at    = i;
        rise_clken = last_clken;
      end
      prev_full = full;
    end
    rxd = 1'b1;
  endtask

  task automatic rx_frame(input string tag, input logic [7:0] ch, input int nbits,
                          input bit pen, input bit peven, input bit pbit, input int clr_off);
    exp_t e;
    int   ones;
    bit   total_odd, full_before;
    length  = 2'(nbits - 5);
    parEN   = pen;
    parEVEN = peven;
    ones = 0;
    for (int b = 0; b < nbits; b++) ones += int'(ch[b]);
    total_odd = ((ones + int'(pbit)) % 2) == 1;
    e.data = ch & (8'hFF >> (8 - nbits));
    e.pare = pen && (peven ? total_odd : !total_odd);
    e.frme = 1'b0;
    e.ovre = model_full && (clr_off < 0);
    sb.push_back(e);
    full_before = full;
    send_frame(ch, nbits, pen, pbit, 1'b1, clr_off);
    model_full = 1;
    if (!full_before) begin
      check({tag, ".full_rose"}, {7'b0, rose}, 8'h01);
      check({tag, ".load_on_clken"}, {7'b0, rise_clken}, 8'h01);
    end
    e = sb.pop_front();
    check({tag, ".data"}, data, e.data);
    check({tag, ".pare"}, {7'b0, pare}, {7'b0, e.pare});
    check({tag, ".frme"}, {7'b0, frme}, {7'b0, e.frme});
    check({tag, ".ovre"}, {7'b0, ovre}, {7'b0, e.ovre});
    check({tag, ".full"}, {7'b0, full}, {7'b0, model_full});
  endtask

  // Inter-frame idle of exactly one bit time, optionally consuming the data.
  task automatic gap(input bit do_clr);
    if (do_clr) begin
      clr = 1'b1;
      tick();
      clr = 1'b0;
      model_full = 0;
      check("clr_clears_full", {7'b0, full}, 8'h00);
      repeat (63) tick();
    end else begin
      repeat (64) tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".data"}, data, 8'h00);
    check({tag, ".full"}, {7'b0, full}, 8'h00);
    check({tag, ".pare"}, {7'b0, pare}, 8'h00);
    check({tag, ".frme"}, {7'b0, frme}, 8'h00);
    check({tag, ".ovre"}, {7'b0, ovre}, 8'h00);
  endtask

  initial begin
    int saved_rise;
    rst     = 1'b1;
    rxd     = 1'b1;
    clr     = 1'b0;
    length  = 2'b11;
    parEN   = 1'b0;
    parEVEN = 1'b0;
    repeat (4) tick();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (64) tick();

    rx_frame("8N1_55", 8'h55, 8, 0, 0, 0, -1);
    gap(1);

    rx_frame("7E1_41_p0", 8'h41, 7, 1, 1, 0, -1);
    gap(1);
    rx_frame("7E1_41_p1", 8'h41, 7, 1, 1, 1, -1);
    gap(1);
    rx_frame("7O1_41_p0", 8'h41, 7, 1, 0, 0, -1);
    gap(1);

    rx_frame("5N1_1F", 8'h1F, 5, 0, 0, 0, -1);
    check("5N1_1F.upper", {5'b0, data[7:5]}, 8'h00);
    gap(1);

    // Short low glitch must be rejected as a false start.
    length = 2'b11;
    parEN  = 1'b0;
    rxd    = 1'b0;
    repeat (16) tick();
    rxd = 1'b1;
    repeat (704) tick();
    check("glitch.full", {7'b0, full}, 8'h00);

    rx_frame("ovr_first", 8'h12, 8, 0, 0, 0, -1);
    gap(0);
    rx_frame("ovr_second", 8'h34, 8, 0, 0, 0, -1);
    gap(1);

    rx_frame("col_first", 8'h12, 8, 0, 0, 0, -1);
    saved_rise = rise_at;
    gap(0);
    rx_frame("col_second", 8'h34, 8, 0, 0, 0, saved_rise);
    gap(1);

    // Break: one load with a framing error, then nothing until rxd recovers.
    rxd = 1'b0;
    repeat (640) tick();
    check("break.full", {7'b0, full}, 8'h01);
    check("break.data", data, 8'h00);
    check("break.frme", {7'b0, frme}, 8'h01);
    check("break.pare", {7'b0, pare}, 8'h00);
    check("break.ovre", {7'b0, ovre}, 8'h00);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_full = 0;
    repeat (1279) tick();
    check("break.no_reload", {7'b0, full}, 8'h00);
    rxd = 1'b1;
    repeat (64) tick();

    rx_frame("after_break_A5", 8'hA5, 8, 0, 0, 0, -1);
    gap(0);

    // Abort a frame part-way through with reset while a character is pending.
    rxd = 1'b0;
    repeat (64) tick();
    for (int b = 0; b < 3; b++) begin
      rxd = b[0];
      repeat (64) tick();
    end
    rst = 1'b1;
    repeat (2) tick();
    check_all_zero("midframe_reset");
    rxd = 1'b1;
    rst = 1'b0;
    model_full = 0;
    repeat (62) tick();

    rx_frame("after_reset_3C", 8'h3C, 8, 0, 0, 0, -1);
    gap(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
